// File: rtl/scu_isa_pkg.sv
// SCU instruction set: opcode values, field positions, operand-usage decode and the issued bundle.
package scu_isa_pkg;

  localparam int INSTR_W  = 32;
  localparam int REG_AW   = 6;
  localparam int NUM_REGS = 64;

  localparam int OP_LSB = 28;
  localparam int RD_LSB = 22;
  localparam int RS_LSB = 16;
  localparam int RT_LSB = 10;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_ST   = 4'h3;
  localparam opcode_t OP_ADD  = 4'h4;
  localparam opcode_t OP_INC  = 4'h5;
  localparam opcode_t OP_NEG  = 4'h6;
  localparam opcode_t OP_SUB  = 4'h7;
  localparam opcode_t OP_J    = 4'h8;
  localparam opcode_t OP_BRZ  = 4'h9;
  localparam opcode_t OP_JM   = 4'hA;
  localparam opcode_t OP_BRN  = 4'hB;
  localparam opcode_t OP_LD   = 4'hE;
  localparam opcode_t OP_SVPC = 4'hF;

  typedef struct packed {
    opcode_t             opcode;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic                regwrt;
  } bundle_t;

  function automatic logic writes_rd(input opcode_t op);
    case (op)
      OP_SVPC, OP_LD, OP_ADD, OP_INC, OP_NEG, OP_SUB: writes_rd = 1'b1;
      default:                                        writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs(input opcode_t op);
    case (op)
      OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
      OP_J, OP_BRZ, OP_JM, OP_BRN: uses_rs = 1'b1;
      default:                     uses_rs = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt(input opcode_t op);
    case (op)
      OP_ST, OP_ADD, OP_SUB: uses_rt = 1'b1;
      default:               uses_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending-write bits; set on issue, cleared by writeback or by killing the issued slot.
// SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback hides the pend bit from the hazard lookups.
module decode_scoreboard
  import scu_isa_pkg::*;
#(
  parameter int REG_AW   = 6,
  parameter int NUM_REGS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_reg,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_reg,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_reg,
  input  logic [REG_AW-1:0] rs_reg,
  input  logic [REG_AW-1:0] rt_reg,
  input  logic [REG_AW-1:0] rd_reg,
  output logic              rs_pend,
  output logic              rt_pend,
  output logic              rd_pend
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] pend_view;

  always_comb begin
    wb_mask = '0;
    if (clr_en) wb_mask[clr_reg] = 1'b1;
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The register file writes and reads on the same edge, so a retiring write needs no wait.
  assign pend_view = pend & ~wb_mask;
`else
  assign pend_view = pend;
`endif

  assign rs_pend = pend_view[rs_reg];
  assign rt_pend = pend_view[rt_reg];
  assign rd_pend = pend_view[rd_reg];

  always_comb begin
    pend_nxt = pend & ~wb_mask;
    if (kill_en) pend_nxt[kill_reg] = 1'b0;
    // A new issue to the same register outranks the retiring write.
    if (set_en)  pend_nxt[set_reg]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode and issue with scoreboard hazard stall; one registered output slot (latency 1 cycle).
// Intake stalls on hazard, flush, or a full slot that is not being consumed.
module decode_issue_stage
  import scu_isa_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int REG_AW   = 6,
  parameter int NUM_REGS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic [REG_AW-1:0]  out_rd,
  output logic [REG_AW-1:0]  out_rs,
  output logic [REG_AW-1:0]  out_rt,
  output logic               out_regwrt,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic               flush
);

  bundle_t           dec;
  bundle_t           slot;
  logic [RT_LSB-1:0] unused_imm;
  logic              dec_rs_use;
  logic              dec_rt_use;
  logic              rs_pend;
  logic              rt_pend;
  logic              rd_pend;
  logic              hazard;
  logic              accept;
  logic              kill;

  assign dec.opcode = in_instr[OP_LSB +: 4];
  assign dec.rd     = in_instr[RD_LSB +: REG_AW];
  assign dec.rs     = in_instr[RS_LSB +: REG_AW];
  assign dec.rt     = in_instr[RT_LSB +: REG_AW];
  assign dec.regwrt = writes_rd(dec.opcode);
  assign dec_rs_use = uses_rs(dec.opcode);
  assign dec_rt_use = uses_rt(dec.opcode);
  assign unused_imm = in_instr[RT_LSB-1:0];

  // Only a slot that is not leaving this cycle can be killed; a consumed one keeps its pend bit.
  assign kill = flush & out_valid & ~out_ready & slot.regwrt;

  decode_scoreboard #(
    .REG_AW   (REG_AW),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept & dec.regwrt),
    .set_reg  (dec.rd),
    .clr_en   (wb_valid),
    .clr_reg  (wb_rd),
    .kill_en  (kill),
    .kill_reg (slot.rd),
    .rs_reg   (dec.rs),
    .rt_reg   (dec.rt),
    .rd_reg   (dec.rd),
    .rs_pend  (rs_pend),
    .rt_pend  (rt_pend),
    .rd_pend  (rd_pend)
  );

  assign hazard   = (dec_rs_use & rs_pend) | (dec_rt_use & rt_pend) | (dec.regwrt & rd_pend);
  assign in_ready = rst_n & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      slot      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      slot      <= dec;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_opcode = slot.opcode;
  assign out_rd     = slot.rd;
  assign out_rs     = slot.rs;
  assign out_rt     = slot.rt;
  assign out_regwrt = slot.regwrt;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed and randomized checks of decode_issue_stage against an opcode-table / register-array model.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [5:0]  out_rd;
  logic [5:0]  out_rs;
  logic [5:0]  out_rt;
  logic        out_regwrt;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic        flush;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_regwrt (out_regwrt),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush)
  );

  // Opcode membership sets, bit n set when opcode n has the property.
  logic [15:0] wr_set = 16'hC0F0;
  logic [15:0] rs_set = 16'h4FF8;
  logic [15:0] rt_set = 16'h0098;

  int   errors = 0;
  int   checks = 0;
  bit   byp_on;
  bit   pend_m [64];
  bit   m_vld;
  logic [3:0] m_op;
  logic [5:0] m_rd, m_rs, m_rt;
  bit   m_wr;
  logic seen_rdy, seen_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] rd,
                                     input logic [5:0] rs, input logic [5:0] rt);
    logic [9:0] junk;
    junk = 10'($urandom);
    return {op, rd, rs, rt, junk};
  endfunction

  function automatic bit busy(input logic [5:0] r, input logic wv, input logic [5:0] wr);
    return pend_m[r] && !(byp_on && wv && wr == r);
  endfunction

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    m_vld = 0; m_op = '0; m_rd = '0; m_rs = '0; m_rt = '0; m_wr = 0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                     input logic wv, input logic [5:0] wr, input logic fl);
    logic [3:0] op;
    logic [5:0] rd, rs, rt;
    bit haz, e_rdy, acc;
    in_valid = iv; in_instr = ins; out_ready = ordy; wb_valid = wv; wb_rd = wr; flush = fl;
    op = ins[31:28]; rd = ins[27:22]; rs = ins[21:16]; rt = ins[15:10];
    @(negedge clk);
    haz = (rs_set[op] && busy(rs, wv, wr)) || (rt_set[op] && busy(rt, wv, wr)) ||
          (wr_set[op] && busy(rd, wv, wr));
    e_rdy = !fl && !haz && (!m_vld || ordy);
    seen_rdy = in_ready;
    seen_vld = out_valid;
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, m_vld);
    chk("out_fields", {out_opcode, out_rd, out_rs, out_rt, out_regwrt},
        {m_op, m_rd, m_rs, m_rt, m_wr});
    acc = iv && e_rdy;
    @(posedge clk);
    if (wv) pend_m[wr] = 1'b0;
    if (fl && m_vld && !ordy && m_wr) pend_m[m_rd] = 1'b0;
    if (acc && wr_set[op]) pend_m[rd] = 1'b1;
    if (acc) begin
      m_vld = 1; m_op = op; m_rd = rd; m_rs = rs; m_rt = rt; m_wr = wr_set[op];
    end else if (fl || ordy) begin
      m_vld = 0;
    end
    #1;
  endtask

  initial begin
`ifdef SCOREBOARD_WB_BYPASS_EN
    byp_on = 1'b1;
`else
    byp_on = 1'b0;
`endif
    model_reset();
    rst_n = 1'b0; in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    #2;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_fields", {out_opcode, out_rd, out_rs, out_rt, out_regwrt}, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // RAW: ADD r3,r1,r2 then ADD r4,r3,r3
    cyc(1, mk(4'h4, 3, 1, 2), 1, 0, 0, 0);
    cyc(1, mk(4'h4, 4, 3, 3), 1, 0, 0, 0);
    chk("raw_stall", seen_rdy, 0);
    cyc(1, mk(4'h4, 4, 3, 3), 1, 1, 3, 0);
    chk("raw_wb_cycle", seen_rdy, byp_on);
    cyc(1, mk(4'h4, 4, 3, 3), 1, 0, 0, 0);
    chk("raw_release", seen_rdy, !byp_on);
    cyc(0, '0, 1, 1, 4, 0);

    // ST stream, no pending sources
    for (int i = 0; i < 4; i++) begin
      cyc(1, mk(4'h3, 6'(i), 5, 6), 1, 0, 0, 0);
      chk("st_stream", seen_rdy, 1);
    end

    // Backpressure holds the slot
    cyc(1, mk(4'h4, 10, 1, 2), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, mk(4'h3, 0, 1, 2), 0, 0, 0, 0);
      chk("bp_stall", seen_rdy, 0);
    end
    cyc(1, mk(4'h3, 0, 1, 2), 1, 0, 0, 0);
    chk("bp_release", seen_rdy, 1);
    cyc(0, '0, 1, 1, 10, 0);

    // Flush kills LD r7 and its pend bit
    cyc(1, mk(4'hE, 7, 1, 0), 0, 0, 0, 0);
    cyc(1, mk(4'h4, 12, 1, 2), 0, 0, 0, 1);
    chk("flush_block", seen_rdy, 0);
    cyc(1, mk(4'h4, 13, 7, 7), 1, 0, 0, 0);
    chk("flush_kill_vld", seen_vld, 0);
    chk("flush_kill_pend", seen_rdy, 1);
    cyc(0, '0, 1, 1, 13, 0);

    // Same-edge issue and writeback of r9: set wins
    cyc(1, mk(4'h7, 9, 1, 2), 1, 1, 9, 0);
    cyc(1, mk(4'h4, 14, 9, 1), 1, 1, 9, 0);
    chk("set_wins_bypass", seen_rdy, byp_on);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 1, 1, 14, 0);

    // Undefined opcode 0x2 decodes as NOP
    cyc(1, mk(4'h2, 20, 20, 20), 1, 0, 0, 0);
    cyc(1, mk(4'h2, 20, 20, 20), 1, 0, 0, 0);
    chk("undef_no_stall", seen_rdy, 1);
    chk("undef_regwrt", out_regwrt, 0);

    // Randomized traffic on a small register window
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 8),
          mk(4'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
             6'($urandom_range(0, 7))),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 2) == 0),
          6'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end
    for (int r = 0; r < 64; r++) cyc(0, '0, 1, 1, 6'(r), 0);

    // Async reset in the middle of a stall
    cyc(1, mk(4'h4, 3, 1, 2), 1, 0, 0, 0);
    cyc(1, mk(4'h4, 5, 3, 1), 0, 0, 0, 0);
    chk("pre_reset_stall", seen_rdy, 0);
    in_valid = 1; in_instr = mk(4'h4, 5, 3, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    model_reset();
    in_valid = 0; wb_valid = 1; wb_rd = 3;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, mk(4'h4, 5, 3, 1), 1, 0, 0, 0);
    chk("post_reset_clear", seen_rdy, 1);
    cyc(0, '0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
